// File: rtl/jaxa_link_pkg.sv
// Shared encodings for the JAXA link controller: FSM states, register map and bit positions.
package jaxa_link_pkg;

    typedef enum logic [2:0] {
        StOff     = 3'd0,
        StWaitRun = 3'd1,
        StRun     = 3'd2,
        StBackoff = 3'd3,
        StFail    = 3'd4
    } state_e;

    localparam logic [1:0] AddrCtrl    = 2'd0;
    localparam logic [1:0] AddrStatus  = 2'd1;
    localparam logic [1:0] AddrTimeout = 2'd2;
    localparam logic [1:0] AddrEvent   = 2'd3;

    localparam int unsigned CtrlEnable    = 0;
    localparam int unsigned CtrlAutostart = 1;
    localparam int unsigned CtrlIrqEn     = 2;
    localparam int unsigned CtrlForceOff  = 3;

    localparam int unsigned EvLinkUp   = 0;
    localparam int unsigned EvLinkLost = 1;
    localparam int unsigned EvRetryExh = 2;
    localparam int unsigned EvFlag0    = 3;
    localparam int unsigned EvFlag1    = 4;

    localparam int unsigned RetryW = 4;

endpackage

// File: rtl/jaxa_link_timer.sv
// Loadable down-counter shared by the link-up timeout and the retry backoff.
module jaxa_link_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/jaxa_link_ctrl.sv
// Avalon-MM controlled link bring-up FSM with timeout, backoff retries and W1C event interrupt.
module jaxa_link_ctrl
    import jaxa_link_pkg::*;
#(
    parameter int unsigned           TIMEOUT_W   = 16,
    parameter logic [TIMEOUT_W-1:0]  TIMEOUT_DEF = TIMEOUT_W'(50000),
    parameter int unsigned           BACKOFF_CYC = 64,
    parameter int unsigned           MAX_RETRY   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        link_running,
    input  logic [1:0]  ctrl_flags_in,
    output logic        link_start,
    output logic        link_autostart,
    output logic        link_disable,
    output logic        irq
);

    localparam int unsigned BoW  = $clog2(BACKOFF_CYC + 1);
    localparam int unsigned CntW = (TIMEOUT_W > BoW) ? TIMEOUT_W : BoW;
    localparam logic [RetryW-1:0] MaxRetry = RetryW'(MAX_RETRY);

    state_e                state_d, state_q;
    logic [3:0]            ctrl_d, ctrl_q;
    logic [TIMEOUT_W-1:0]  timeout_d, timeout_q;
    logic [4:0]            ev_d, ev_q, ev_set;
    logic [RetryW-1:0]     retry_d, retry_q, retry_inc;
    logic [1:0]            flags_q;
    logic [31:0]           rdata_d;
    logic                  start_d, disable_d, auto_d, irq_d;
    logic                  tmr_load, tmr_en, tmr_zero;
    logic [CntW-1:0]       tmr_val;
    logic                  go_off;
    logic                  unused_wdata;

    assign unused_wdata = ^writedata;

    jaxa_link_timer #(
        .W (CntW)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    assign go_off    = !ctrl_q[CtrlEnable] || ctrl_q[CtrlForceOff];
    assign retry_inc = (retry_q >= MaxRetry) ? retry_q : retry_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        ev_set   = {ctrl_flags_in & ~flags_q, 3'b000};
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = CntW'(timeout_q);
        case (state_q)
            StOff: begin
                state_d  = StWaitRun;
                tmr_load = 1'b1;
                retry_d  = '0;
            end
            StWaitRun: begin
                if (link_running) begin
                    state_d          = StRun;
                    ev_set[EvLinkUp] = 1'b1;
                    retry_d          = '0;
                end else if (tmr_zero) begin
                    retry_d = retry_inc;
                    if (retry_inc == MaxRetry) begin
                        state_d            = StFail;
                        ev_set[EvRetryExh] = 1'b1;
                    end else begin
                        state_d  = StBackoff;
                        tmr_load = 1'b1;
                        tmr_val  = CntW'(BACKOFF_CYC - 1);
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            StRun: begin
                if (!link_running) begin
                    state_d            = StBackoff;
                    ev_set[EvLinkLost] = 1'b1;
                    tmr_load           = 1'b1;
                    tmr_val            = CntW'(BACKOFF_CYC - 1);
                end
            end
            StBackoff: begin
                if (tmr_zero) begin
                    state_d  = StWaitRun;
                    tmr_load = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            StFail:  state_d = StFail;
            default: state_d = StOff;
        endcase
        // Disable/force-off beats every transition, including the OFF exit above.
        if (go_off) begin
            state_d     = StOff;
            retry_d     = retry_q;
            ev_set[2:0] = 3'b000;
            tmr_load    = 1'b0;
            tmr_en      = 1'b0;
        end
    end

    always_comb begin
        ctrl_d    = ctrl_q;
        timeout_d = timeout_q;
        ev_d      = ev_q;
        if (write) begin
            case (address)
                AddrCtrl:    ctrl_d    = writedata[3:0];
                AddrTimeout: timeout_d = writedata[TIMEOUT_W-1:0];
                AddrEvent:   ev_d      = ev_q & ~writedata[4:0];
                default:     ;
            endcase
        end
        // Hardware set is applied after the W1C clear so it wins a collision.
        ev_d = ev_d | ev_set;

        case (address)
            AddrCtrl:    rdata_d = {28'd0, ctrl_q};
            AddrStatus:  rdata_d = {20'd0, retry_q, 2'b00, ctrl_flags_in, link_running, state_q};
            AddrTimeout: rdata_d = 32'(timeout_q);
            default:     rdata_d = {27'd0, ev_q};
        endcase

        start_d   = (state_d == StWaitRun) || (state_d == StRun);
        disable_d = !start_d;
        auto_d    = start_d && ctrl_q[CtrlAutostart];
        irq_d     = ctrl_q[CtrlIrqEn] && (|ev_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= StOff;
            ctrl_q         <= '0;
            timeout_q      <= TIMEOUT_DEF;
            ev_q           <= '0;
            retry_q        <= '0;
            flags_q        <= '0;
            readdata       <= '0;
            irq            <= 1'b0;
            link_start     <= 1'b0;
            link_autostart <= 1'b0;
            link_disable   <= 1'b1;
        end else begin
            state_q        <= state_d;
            ctrl_q         <= ctrl_d;
            timeout_q      <= timeout_d;
            ev_q           <= ev_d;
            retry_q        <= retry_d;
            flags_q        <= ctrl_flags_in;
            readdata       <= rdata_d;
            irq            <= irq_d;
            link_start     <= start_d;
            link_autostart <= auto_d;
            link_disable   <= disable_d;
        end
    end

endmodule

// File: tb/tb_jaxa_link_ctrl.sv
// Directed self-checking bench for jaxa_link_ctrl.
module tb_jaxa_link_ctrl;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        link_running;
    logic [1:0]  ctrl_flags_in;
    logic        link_start;
    logic        link_autostart;
    logic        link_disable;
    logic        irq;

    int checks = 0;
    int errors = 0;

    jaxa_link_ctrl #(
        .TIMEOUT_W   (16),
        .TIMEOUT_DEF (16'd50000),
        .BACKOFF_CYC (64),
        .MAX_RETRY   (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .address        (address),
        .write          (write),
        .writedata      (writedata),
        .readdata       (readdata),
        .link_running   (link_running),
        .ctrl_flags_in  (ctrl_flags_in),
        .link_start     (link_start),
        .link_autostart (link_autostart),
        .link_disable   (link_disable),
        .irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({readdata, irq, link_start, link_autostart, link_disable} !== {32'd0, 4'b0001}) begin
            errors++;
            $display("FAIL reset_outputs got rd=%h irq=%b st=%b au=%b dis=%b want 0 0 0 0 1",
                     readdata, irq, link_start, link_autostart, link_disable);
        end
        reset_n = 1'b1;
        rd(2'd0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", d); end
        rd(2'd2, d);
        checks++;
        if (d !== 32'd50000) begin errors++; $display("FAIL reset_timeout got %h want c350", d); end
        rd(2'd1, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_status got %h want 0", d); end
        rd(2'd3, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_event got %h want 0", d); end
    endtask

    task automatic test_bringup();
        logic [31:0] d;
        wr(2'd0, 32'h1);
        tick();
        checks++;
        if ({link_start, link_disable, link_autostart} !== 3'b100) begin
            errors++;
            $display("FAIL bringup_wait got st/dis/au=%b%b%b want 100",
                     link_start, link_disable, link_autostart);
        end
        repeat (8) tick();
        link_running = 1'b1;
        tick();
        checks++;
        if (link_start !== 1'b1) begin errors++; $display("FAIL bringup_run_start got %b want 1", link_start); end
        rd(2'd1, d);
        checks++;
        if (d !== 32'h0000_000a) begin errors++; $display("FAIL bringup_status got %h want 0000000a", d); end
        rd(2'd3, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL bringup_event got %h want 1", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL bringup_irq got %b want 0", irq); end
        wr(2'd3, 32'h1f);
    endtask

    task automatic test_link_loss();
        logic [31:0] d;
        wr(2'd0, 32'h5);
        link_running = 1'b0;
        tick();
        tick();
        checks++;
        if ({irq, link_disable, link_start} !== 3'b110) begin
            errors++;
            $display("FAIL loss_irq got irq/dis/st=%b%b%b want 110", irq, link_disable, link_start);
        end
        rd(2'd3, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL loss_event got %h want 2", d); end
        rd(2'd1, d);
        checks++;
        if (d !== 32'h3) begin errors++; $display("FAIL loss_status got %h want 3", d); end
        wr(2'd3, 32'h2);
        tick();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL loss_irq_clear got %b want 0", irq); end
        wr(2'd0, 32'h0);
        tick();
    endtask

    task automatic test_collision();
        logic [31:0] d;
        ctrl_flags_in = 2'b01;
        wr(2'd3, 32'h8);
        rd(2'd3, d);
        checks++;
        if (d !== 32'h8) begin errors++; $display("FAIL collide_set_wins got %h want 8", d); end
        wr(2'd3, 32'h8);
        rd(2'd3, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL collide_w1c got %h want 0", d); end
        ctrl_flags_in = 2'b11;
        tick();
        rd(2'd3, d);
        checks++;
        if (d !== 32'h10) begin errors++; $display("FAIL flag1_rise got %h want 10", d); end
        ctrl_flags_in = 2'b00;
        tick();
        wr(2'd3, 32'h1f);
    endtask

    task automatic test_force_off();
        logic [31:0] d;
        wr(2'd0, 32'h1);
        tick();
        checks++;
        if (link_start !== 1'b1) begin errors++; $display("FAIL force_pre got %b want 1", link_start); end
        wr(2'd0, 32'h9);
        tick();
        checks++;
        if ({link_disable, link_start} !== 2'b10) begin
            errors++;
            $display("FAIL force_off got dis/st=%b%b want 10", link_disable, link_start);
        end
        rd(2'd1, d);
        checks++;
        if (d[2:0] !== 3'd0) begin errors++; $display("FAIL force_state got %0d want 0", d[2:0]); end
        wr(2'd0, 32'h0);
        tick();
    endtask

    task automatic test_retry();
        logic [31:0] d;
        int falls = 0;
        int n = 0;
        logic prev = 1'b0;
        wr(2'd2, 32'd20);
        rd(2'd2, d);
        checks++;
        if (d !== 32'd20) begin errors++; $display("FAIL retry_timeout_reg got %h want 14", d); end
        wr(2'd0, 32'h1);
        for (int i = 1; i <= 2000; i++) begin
            tick();
            if (prev && !link_start) falls++;
            prev = link_start;
            if (falls == 4) begin
                n = i;
                break;
            end
        end
        checks++;
        if (falls != 4) begin errors++; $display("FAIL retry_bound got %0d timeouts want 4", falls); end
        checks++;
        if (n != 277) begin errors++; $display("FAIL retry_cycles got %0d want 277", n); end
        checks++;
        if (link_disable !== 1'b1) begin errors++; $display("FAIL retry_disable got %b want 1", link_disable); end
        rd(2'd1, d);
        checks++;
        if (d !== 32'h404) begin errors++; $display("FAIL retry_status got %h want 404", d); end
        rd(2'd3, d);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL retry_event got %h want 4", d); end
        repeat (100) tick();
        rd(2'd1, d);
        checks++;
        if ({d[2:0], link_disable, link_start} !== {3'd4, 2'b10}) begin
            errors++;
            $display("FAIL fail_sticky got state=%0d dis=%b st=%b want 4 1 0", d[2:0], link_disable, link_start);
        end
        wr(2'd0, 32'h0);
        tick();
        rd(2'd1, d);
        checks++;
        if (d[2:0] !== 3'd0) begin errors++; $display("FAIL fail_exit got %0d want 0", d[2:0]); end
        wr(2'd3, 32'h1f);
    endtask

    task automatic test_timeout_zero();
        logic [31:0] d;
        wr(2'd2, 32'd0);
        wr(2'd0, 32'h1);
        tick();
        checks++;
        if (link_start !== 1'b1) begin errors++; $display("FAIL tz_wait got %b want 1", link_start); end
        tick();
        checks++;
        if ({link_start, link_disable} !== 2'b01) begin
            errors++;
            $display("FAIL tz_backoff got st/dis=%b%b want 01", link_start, link_disable);
        end
        rd(2'd1, d);
        checks++;
        if (d !== 32'h103) begin errors++; $display("FAIL tz_status got %h want 103", d); end
        wr(2'd0, 32'h0);
        tick();
        wr(2'd3, 32'h1f);
    endtask

    task automatic test_midreset();
        logic [31:0] d;
        link_running = 1'b1;
        wr(2'd0, 32'h7);
        tick();
        tick();
        checks++;
        if ({link_start, link_autostart} !== 2'b11) begin
            errors++;
            $display("FAIL mr_run got st/au=%b%b want 11", link_start, link_autostart);
        end
        tick();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL mr_irq got %b want 1", irq); end
        reset_n = 1'b0;
        tick();
        checks++;
        if ({readdata, irq, link_start, link_autostart, link_disable} !== {32'd0, 4'b0001}) begin
            errors++;
            $display("FAIL mr_outputs got rd=%h irq=%b st=%b au=%b dis=%b want 0 0 0 0 1",
                     readdata, irq, link_start, link_autostart, link_disable);
        end
        reset_n = 1'b1;
        rd(2'd0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL mr_ctrl got %h want 0", d); end
        rd(2'd2, d);
        checks++;
        if (d !== 32'd50000) begin errors++; $display("FAIL mr_timeout got %h want c350", d); end
        rd(2'd3, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL mr_event got %h want 0", d); end
        rd(2'd1, d);
        checks++;
        if (d !== 32'h8) begin errors++; $display("FAIL mr_status got %h want 8", d); end
    endtask

    initial begin
        reset_n       = 1'b0;
        address       = 2'd0;
        write         = 1'b0;
        writedata     = 32'd0;
        link_running  = 1'b0;
        ctrl_flags_in = 2'b00;
        test_reset();
        test_bringup();
        test_link_loss();
        test_collision();
        test_force_off();
        test_retry();
        test_timeout_zero();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jaxa_link_ctrl.md
JAXA_LINK_CTRL -- requirements
Module: jaxa_link_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 16, width of the link-up timeout counter.
REQ-002 SHALL have parameter TIMEOUT_DEF, default 16'd50000, reset value of the TIMEOUT register in cycles.
REQ-003 SHALL have parameter BACKOFF_CYC, default 64, cycles `link_disable` is held between retries.
REQ-004 SHALL have parameter MAX_RETRY, default 4, failed attempts allowed before entering FAIL.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, reset, synchronous and active-low.
REQ-007 SHALL have port address, input, 2, Avalon-MM word address.
REQ-008 SHALL have port write, input, 1, Avalon-MM write strobe.
REQ-009 SHALL have port writedata, input, 32, Avalon-MM write data.
REQ-010 SHALL have port readdata, output, 32, registered Avalon-MM read data.
REQ-011 SHALL have port link_running, input, 1, codec link-running status.
REQ-012 SHALL have port ctrl_flags_in, input, 2, codec control flags.
REQ-013 SHALL have port link_start, output, 1, codec link-start request.
REQ-014 SHALL have port link_autostart, output, 1, codec autostart request.
REQ-015 SHALL have port link_disable, output, 1, codec link-disable request.
REQ-016 SHALL have port irq, output, 1, level interrupt.

Function
REQ-017 SHALL decode the register map as follows.
- 0 CTRL (RW): bit0 enable, bit1 autostart, bit2 irq_en, bit3 force_off.
- 1 STATUS (RO): [2:0] state, bit3 link_running, [5:4] ctrl_flags_in, [11:8] retry_cnt.
- 2 TIMEOUT (RW): [TIMEOUT_W-1:0].
- 3 EVENT (W1C): bit0 link_up, bit1 link_lost, bit2 retry_exhausted, [4:3] rising edge of ctrl_flags_in[1:0].
REQ-018 SHALL update readdata every cycle from `address`, giving one cycle of latency with no read strobe; unused bits SHALL read 0.
REQ-019 SHALL implement FSM states OFF=0, WAIT_RUN=1, RUN=2, BACKOFF=3, FAIL=4.
REQ-020 SHALL apply the following transitions from OFF.
- Go to WAIT_RUN when enable=1 and force_off=0.
- On that entry, load the timer with TIMEOUT and set retry_cnt=0.
REQ-021 SHALL apply the following transitions from WAIT_RUN.
- If link_running=1: go to RUN, set EVENT.link_up, and clear retry_cnt.
- Else, if timer==0: increment retry_cnt.
- On timeout, if the new retry_cnt==MAX_RETRY: go to FAIL and set retry_exhausted.
- On timeout otherwise: go to BACKOFF.
- Otherwise: decrement the timer.
REQ-022 SHALL apply the following transitions from RUN.
- On link_running=0: set link_lost, go to BACKOFF, and leave retry_cnt unchanged.
REQ-023 SHALL apply the following transitions from BACKOFF.
- Count BACKOFF_CYC cycles, then go to WAIT_RUN and reload the timer.
REQ-024 SHALL exit FAIL only when enable=0, going to OFF.
REQ-025 SHALL go to OFF on the next edge from any state when enable=0 or force_off=1; this overrides every other transition.
REQ-026 SHALL register the outputs as follows.
- link_start=1 in WAIT_RUN and RUN.
- link_disable=1 in OFF, BACKOFF and FAIL.
- link_autostart = CTRL.autostart while in WAIT_RUN or RUN, else 0.
- link_start and link_disable SHALL never both be 1.
REQ-027 SHALL, on the same cycle, give a hardware EVENT set priority over a W1C clear of the same bit.
REQ-028 SHALL detect ctrl_flags_in edges against a one-cycle-delayed copy; the input is synchronous to clk.
REQ-029 SHALL register irq = irq_en & |EVENT[4:0].
REQ-030 SHALL saturate retry_cnt at MAX_RETRY.
REQ-031 SHALL make a TIMEOUT write take effect at the next timer load, not mid-count.
REQ-032 SHALL treat TIMEOUT=0 as an immediate timeout in WAIT_RUN, with one attempt consumed per pass.

Reset
REQ-033 SHALL, while reset_n=0 at a clock edge, set the following.
- state=OFF.
- CTRL=0, TIMEOUT=TIMEOUT_DEF, EVENT=0.
- retry_cnt=0 and all counters 0.
- readdata=0, irq=0, link_start=0, link_autostart=0, link_disable=1.
- Flag history = 0.
REQ-034 SHALL abandon any attempt in progress when reset is asserted mid-operation, with no event recorded.

Structure
REQ-035 SHALL place the state encoding, register addresses, and CTRL/EVENT bit indices in shared package jaxa_link_pkg.
REQ-036 SHALL implement the timeout/backoff down-counter as sub-module jaxa_link_timer (load, enable, zero flag); all other logic SHALL be flat.

Verification
REQ-037 SHALL cover bring-up: write CTRL=0x1, raise link_running at cycle 10 -> WAIT_RUN with link_start=1, then RUN, EVENT=0x1, irq=0 (irq_en=0).
REQ-038 SHALL cover retry exhaustion: TIMEOUT=20, MAX_RETRY=4, link_running held 0 -> 4 timeout/backoff cycles, then FAIL, EVENT.bit2=1, link_disable=1, STATUS[11:8]=4.
REQ-039 SHALL cover link loss plus interrupt: CTRL=0x5 in RUN, drop link_running -> link_lost set, irq=1 the next cycle, BACKOFF; W1C writing 0x2 -> irq=0.
REQ-040 SHALL cover set/clear collision: ctrl_flags_in 0->1 on the same cycle as a W1C of 0x8 -> EVENT bit3 remains 1.
REQ-041 SHALL cover force-off mid-attempt: write CTRL=0x9 in WAIT_RUN -> OFF next cycle, link_disable=1, link_start=0.
REQ-042 SHALL cover mid-operation reset: reset_n=0 for one cycle in RUN -> every REQ-033 reset value holds.
